// File: rtl/grid_stream_pkg.sv
// grid_stream_pkg
//   Shared types and width helpers for the grid frame streamer.
//   - state_t  : streamer FSM states (IDLE, STREAM)
//   - clog2    : ceiling log2 usable in constant expressions
//   - idx_w    : bits needed to index n items (at least 1)
//   - cnt_w    : bits needed to hold a count 0..maxv (at least 1)
package grid_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of a counter that walks 0..n-1
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // Width of a counter that must represent 0..maxv inclusive
  function automatic int cnt_w(input int maxv);
    return (maxv < 1) ? 1 : clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/beat_popcount.sv
// beat_popcount
//   Combinational population count of one W-cell beat.
//   Ports:
//     data  (in,  W)     : beat cells
//     count (out, CNT_W) : number of set cells
module beat_popcount #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic [W-1:0]     data,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/grid_frame_streamer.sv
// grid_frame_streamer
//   Snapshots the flattened N x M life grid on request and streams it out in
//   raster order as W-cell beats over valid/ready, tagged with start-of-line,
//   end-of-line and end-of-frame flags. The live grid may keep evolving while
//   the frozen snapshot drains at the sink's pace.
//   Optional feature macro: GRID_STREAM_POPCOUNT_EN adds live_cnt_o, the number
//   of live cells in the most recently completed frame.
//   Ports:
//     clk_i        (in)         rising-edge clock
//     reset_i      (in)         asynchronous active-high reset
//     grid_i       (in,  N*M)   live grid, cell (x,y) at bit y*M+x
//     frame_req_i  (in)         snapshot request, level-sampled
//     busy_o       (out)        frame in flight
//     m_data_o     (out, W)     beat data, bit k = cell (col*W+k, row)
//     m_valid_o    (out)        beat valid
//     m_ready_i    (in)         sink accepts beat
//     m_sol_o      (out)        first beat of a row
//     m_eol_o      (out)        last beat of a row
//     m_eof_o      (out)        last beat of the frame
//     frame_cnt_o  (out, 16)    completed frames, wrapping
//     live_cnt_o   (out)        live cells of last frame (macro only)
//   Legal only when M % W == 0 and W <= M.
module grid_frame_streamer
  import grid_stream_pkg::*;
#(
  parameter int M = 64,
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N*M-1:0]   grid_i,
  input  logic             frame_req_i,
  output logic             busy_o,
  output logic [W-1:0]     m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_sol_o,
  output logic             m_eol_o,
  output logic             m_eof_o,
`ifdef GRID_STREAM_POPCOUNT_EN
  output logic [cnt_w(M*N)-1:0] live_cnt_o,
`endif
  output logic [15:0]      frame_cnt_o
);

  localparam int COLS   = M / W;
  localparam int BEATS  = COLS * N;
  localparam int COL_W  = idx_w(COLS);
  localparam int ROW_W  = idx_w(N);
  localparam int BEAT_W = idx_w(BEATS);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  state_t                   state_q;
  // Snapshot viewed as BEATS consecutive W-bit beats in raster order
  logic [BEATS-1:0][W-1:0]  snap_q;
  logic [COL_W-1:0]         col_q;
  logic [ROW_W-1:0]         row_q;
  logic [15:0]              frame_cnt_q;

  logic                     vld_p0;
  logic                     eol_p0;
  logic                     eof_p0;
  logic [BEAT_W-1:0]        beat_idx;

  // Output stage: pure decode of registered state, counters and snapshot
  assign vld_p0   = (state_q == STREAM);
  assign eol_p0   = vld_p0 && (col_q == LAST_COL);
  assign eof_p0   = eol_p0 && (row_q == LAST_ROW);
  assign beat_idx = BEAT_W'(row_q) * BEAT_W'(COLS) + BEAT_W'(col_q);

  assign m_valid_o   = vld_p0;
  assign busy_o      = vld_p0;
  assign m_data_o    = vld_p0 ? snap_q[beat_idx] : '0;
  assign m_sol_o     = vld_p0 && (col_q == '0);
  assign m_eol_o     = eol_p0;
  assign m_eof_o     = eof_p0;
  assign frame_cnt_o = frame_cnt_q;

`ifdef GRID_STREAM_POPCOUNT_EN
  localparam int LIVE_W = cnt_w(M * N);
  localparam int PC_W   = cnt_w(W);

  logic [PC_W-1:0]   beat_pop;
  logic [LIVE_W-1:0] acc_q;
  logic [LIVE_W-1:0] live_q;

  beat_popcount #(
    .W     (W),
    .CNT_W (PC_W)
  ) u_beat_popcount (
    .data  (m_data_o),
    .count (beat_pop)
  );

  assign live_cnt_o = live_q;
`endif

  // Control/state stage: capture, beat walk, frame completion
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      frame_cnt_q <= '0;
`ifdef GRID_STREAM_POPCOUNT_EN
      acc_q       <= '0;
      live_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_req_i) begin
            snap_q  <= grid_i;
            col_q   <= '0;
            row_q   <= '0;
`ifdef GRID_STREAM_POPCOUNT_EN
            acc_q   <= '0;
`endif
            state_q <= STREAM;
          end
        end

        STREAM: begin
          if (m_ready_i) begin
            if (eof_p0) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
`ifdef GRID_STREAM_POPCOUNT_EN
              live_q      <= acc_q + LIVE_W'(beat_pop);
`endif
              col_q       <= '0;
              row_q       <= '0;
              // A request coinciding with the last beat chains the next
              // frame without an idle cycle; otherwise requests mid-frame
              // are dropped.
              if (frame_req_i) begin
                snap_q <= grid_i;
`ifdef GRID_STREAM_POPCOUNT_EN
                acc_q  <= '0;
`endif
              end else begin
                state_q <= IDLE;
              end
            end else begin
`ifdef GRID_STREAM_POPCOUNT_EN
              acc_q <= acc_q + LIVE_W'(beat_pop);
`endif
              if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
              end else begin
                col_q <= col_q + COL_W'(1);
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/grid_frame_streamer.md
# grid_frame_streamer

- Reader side of the flattened Game-of-Life grid bus.
- Function:
  - On request, snapshots the row-major N×M `grid_i` vector.
  - Streams the snapshot out in raster order as W-cell beats on a valid/ready interface.
  - Marks each beat with start-of-line, end-of-line and end-of-frame flags.
- Placement: between the life-update core and display/host sinks. The core keeps evolving while a frozen frame is drained at the sink's pace.

## Interface
- `M`, default 64: grid columns.
- `N`, default 64: grid rows.
- `W`, default 8: cells per beat. Legal only if M % W == 0 and W ≤ M.
- `clk_i`  in  1  sole clock, rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `grid_i`  in  N*M  live grid. Cell (x,y) is bit y*M+x.
- `frame_req_i`  in  1  level sampled each edge; requests a snapshot.
- `busy_o`  out  1  high while a frame is being streamed.
- `m_data_o`  out  W  bit k = cell (col*W+k, row) of the snapshot.
- `m_valid_o`  out  1  beat valid.
- `m_ready_i`  in  1  sink accepts the beat.
- `m_sol_o`  out  1  first beat of a row.
- `m_eol_o`  out  1  last beat of a row.
- `m_eof_o`  out  1  last beat of the frame.
- `frame_cnt_o`  out  16  completed frames, wraps at 2^16.
- `live_cnt_o`  out  clog2(M*N+1)  live cells in the last completed frame. Present only with the macro.

## Operation
- States: IDLE, STREAM.
- IDLE:
  - `frame_req_i`=1 at an edge captures `grid_i` into the snapshot register.
  - Clears beat column `col` and row `row` to 0.
  - Moves to STREAM.
- STREAM:
  - `m_valid_o`=1 and `busy_o`=1.
  - Handshake: `m_valid_o` && `m_ready_i` at an edge.
  - On each handshake `col` increments. When `col`=M/W-1, `col` wraps to 0 and `row` increments.
- Flags, all derived from `col`/`row`:
  - `m_sol_o` = (`col`==0).
  - `m_eol_o` = (`col`==M/W-1).
  - `m_eof_o` = `m_eol_o` && (`row`==N-1).
- Final handshake (`m_eof_o`):
  - `frame_cnt_o` increments.
  - Returns to IDLE unless `frame_req_i`=1 in the same cycle. In that case the snapshot is re-captured, counters clear, and the state stays in STREAM with no bubble.
- `frame_req_i` in STREAM other than on the final handshake is ignored. It is not queued.
- Stall rule: while `m_valid_o`=1 and `m_ready_i`=0, data and flags hold stable.
- `m_valid_o` never drops before a handshake.
- Changes on `grid_i` after capture never affect the frame in flight.
- Reset (async, any state):
  - State returns to IDLE.
  - Snapshot, `col`, `row`, `frame_cnt_o` and `live_cnt_o` all clear to 0.
  - `m_valid_o`, `busy_o` and `m_data_o` are 0 immediately. Outputs stay 0 in IDLE.

## Timing
- Request sampled at edge k → `m_valid_o`=1 in the cycle after edge k.
- Frame length is M*N/W beats.
- With `m_ready_i` tied high, `busy_o` is high for exactly M*N/W cycles per frame.
- Back-to-back requests sustain 1 beat/cycle.
- All outputs come from registers (state, counters, snapshot) through a combinational W-slice mux only. There is no combinational path from `m_ready_i` or `grid_i` to outputs.

## Configuration
- `GRID_STREAM_POPCOUNT_EN` defined:
  - Accumulator clears on capture.
  - Adds popcount(`m_data_o`) on each handshake.
  - On the final handshake, `live_cnt_o` loads accumulator + popcount of the final beat.
  - Holds between frames; resets to 0.
- `GRID_STREAM_POPCOUNT_EN` undefined:
  - `live_cnt_o`, the accumulator and the popcount logic are absent.
  - All other behaviour is identical.

## Structure
- Package `grid_stream_pkg`:
  - State enum typedef (IDLE, STREAM).
  - clog2 function.
  - Width helpers for `col`/`row`/`live_cnt`.
- Sub-module `beat_popcount`: W-bit combinational popcount. Instantiated only under `GRID_STREAM_POPCOUNT_EN`.
- Snapshot, counters and FSM live in `grid_frame_streamer`.

## Test plan
All scenarios use M=8, N=4, W=4, giving 8 beats per frame.
1. Reset, then `grid_i`=32'h0000_6C40 (R-pentomino slice).
   - Stimulus: 1-cycle `frame_req_i`, `m_ready_i`=1.
   - Response: 8 beats equal to nibbles 0..7 in order.
   - `m_sol_o` on beats 0,2,4,6; `m_eol_o` on 1,3,5,7; `m_eof_o` only on beat 7.
   - `frame_cnt_o`=1 and `busy_o`=0 after.
2. `m_ready_i` toggled in a pseudo-random pattern.
   - Data and flags stable across every stall.
   - Same 8-beat sequence as scenario 1; no beat lost or duplicated.
3. `grid_i` inverted every cycle after capture.
   - Streamed frame equals the value captured at the request edge.
4. `frame_req_i` pulsed mid-frame → ignored.
   - `frame_req_i` held high across the final handshake → next frame begins the following cycle.
   - `frame_cnt_o` goes 1 then 2; no idle cycle between frames.
5. With macro: grid containing 5 live cells → `live_cnt_o`=5 after the eof handshake.
   - Next frame all-zero → `live_cnt_o`=0.
6. Assert `reset_i` between clock edges during beat 3.
   - `m_valid_o`/`busy_o` fall immediately; `frame_cnt_o`=0.
   - A later request restarts from beat 0.
